fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Small first-word-fall-through instruction queue between InstructionMemory/PCAdder and the IF/ID pipeline register. Each entry holds one fetched instruction and its PC+4 value. The queue decouples fetch from ID stalls (IF_ID_Write low) and discards every entry on a branch/jump flush (IF_Flush). When empty it presents a NOP so IF/ID never latches stale data.

Parameters:
DEPTH, 4, number of entries; power of two, 2..16
PTR_W, 2, log2(DEPTH); pointer width; count is PTR_W+1 bits
CNT_W, 16, width of saturating flush-event counter

Ports:
Clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
enq_valid  in  1  fetch presents a valid instruction this cycle
enq_ready  out  1  queue accepts an entry; equals !full
enq_instr  in  32  instruction from InstructionMemory
enq_pc4  in  32  PCAddResult for that instruction
deq_ready  in  1  IF/ID consumes the head (driven by IF_ID_Write)
deq_valid  out  1  head entry valid; equals !empty
deq_instr  out  32  head instruction; 32'h0000_0000 (NOP) when empty
deq_pc4  out  32  head PC+4; 32'h0 when empty
flush  in  1  discard all entries (IF_Flush)
count  out  PTR_W+1  occupied entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
flush_events  out  CNT_W  number of flushes that discarded >=1 entry; saturates

Behaviour:
- Reset (reset==0, async): wr_ptr=0, rd_ptr=0, count=0, flush_events=0; hence empty=1, full=0, deq_valid=0, enq_ready=1, deq_instr=0, deq_pc4=0. Storage array not reset.
- Push = enq_valid & enq_ready & !flush. Pop = deq_valid & deq_ready & !flush.
- Push: write {enq_instr, enq_pc4} at wr_ptr; wr_ptr increments mod DEPTH (natural wrap).
- Pop: rd_ptr increments mod DEPTH.
- count next = count + push - pop; push and pop in the same cycle leave count unchanged.
- Latency: entry pushed in cycle N is visible on deq_* in cycle N+1. No empty bypass: push while empty keeps deq_valid=0 that cycle.
- Full: enq_ready=0; enq_valid ignored even when deq_ready=1 that cycle (no full-bypass; keeps enq_ready free of combinational deq_ready path).
- Empty: deq_ready ignored; outputs forced to NOP/0.
- deq_instr/deq_pc4 are combinational reads of storage at rd_ptr, muxed to 0 when empty.
- Flush (synchronous): next cycle wr_ptr=rd_ptr=0, count=0. Overrides any push/pop in the same cycle; enq data that cycle is dropped. If count!=0 at flush, flush_events increments unless already all-ones.
- Flush while empty: pointers still cleared; flush_events unchanged.
- Reset asserted mid-operation: all state cleared immediately; contents lost; no partial entry survives.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when pointers are equal and full.

Decomposition:
- Shared package: NOP_INSTR = 32'h0000_0000, FQ_DEPTH default, FQ_ENTRY_W = 64 (instr + pc4 packing order {instr, pc4}).
- One sub-module: fetch_queue_mem. DEPTH x 64 register array, one synchronous write port, one asynchronous read port. Pointer/count/flush control lives in fetch_queue.

Test Plan:
- Reset: hold reset=0 2 cycles -> count=0, empty=1, enq_ready=1, deq_instr=32'h0, flush_events=0; release, idle -> unchanged.
- Fill/drain: push 0x20080005/pc4 0x4, 0x20090007/0x8, 0x01095020/0xC, 0xAC0A0000/0x10 with deq_ready=0 -> count=4, full=1, enq_ready=0. Fifth enq_valid ignored. Drain with deq_ready=1 -> same four in order, then empty=1, deq_instr=0.
- Simultaneous push/pop at count=2 for 6 cycles -> count stays 2; output order preserved across pointer wrap.
- Full plus deq_ready: at count=4 assert enq_valid and deq_ready -> pop only, count=3, new data not stored.
- Flush with push: count=3, flush=1 with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0, flush_events=1. Second flush while empty -> flush_events stays 1.
- Async reset mid-stream: count=2, drop reset between clock edges -> count=0 and deq_instr=0 before the next edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants and entry packing for the fetch queue
//   NOP_INSTR  : instruction presented downstream when the queue is empty
//   FQ_DEPTH   : default number of queue entries
//   FQ_ENTRY_W : width of one stored entry, packed as {instr, pc4}
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          FQ_DEPTH   = 4;
  localparam int          FQ_ENTRY_W = 64;

  // Instruction occupies the upper half so a head entry splits as [63:32]/[31:0].
  function automatic logic [FQ_ENTRY_W-1:0] packEntry(input logic [31:0] instr,
                                                      input logic [31:0] pc4);
    return {instr, pc4};
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - DEPTH x FQ_ENTRY_W register array, sync write, async read
//   Clk    : rising-edge clock for the write port
//   wrEn   : write wrData at wrAddr on the next rising edge
//   wrAddr : write slot
//   wrData : packed {instr, pc4} entry
//   rdAddr : read slot
//   rdData : combinational contents of slot rdAddr
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic                  Clk,
  input  logic                  wrEn,
  input  logic [PTR_W-1:0]      wrAddr,
  input  logic [FQ_ENTRY_W-1:0] wrData,
  input  logic [PTR_W-1:0]      rdAddr,
  output logic [FQ_ENTRY_W-1:0] rdData
);

  // Contents are deliberately not reset; the occupancy count in the parent
  // decides whether a slot holds meaningful data.
  logic [FQ_ENTRY_W-1:0] storage [DEPTH];

  always_ff @(posedge Clk) begin
    if (wrEn) begin
      storage[wrAddr] <= wrData;
    end
  end

  assign rdData = storage[rdAddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - first-word-fall-through instruction queue between fetch and IF/ID
//   Clk, reset          : rising-edge clock, asynchronous active-low reset
//   enq_valid/enq_ready : fetch handshake; enq_ready is !full
//   enq_instr/enq_pc4   : fetched instruction and its PC+4
//   deq_valid/deq_ready : IF/ID handshake; deq_ready comes from IF_ID_Write
//   deq_instr/deq_pc4   : head entry, forced to NOP/0 when empty
//   flush               : discard every entry (IF_Flush)
//   count, full, empty  : occupancy status
//   flush_events        : saturating count of flushes that discarded entries
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_instr,
  input  logic [31:0]      enq_pc4,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [31:0]      deq_instr,
  output logic [31:0]      deq_pc4,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic                  pushEn;
  logic                  popEn;
  logic [FQ_ENTRY_W-1:0] headEntry;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign enq_ready = !full;
  assign deq_valid = !empty;

  // Flush wins over both handshakes. Full blocks enqueue even when the head
  // is leaving this cycle, keeping enq_ready independent of deq_ready.
  assign pushEn = enq_valid && enq_ready && !flush;
  assign popEn  = deq_valid && deq_ready && !flush;

  fetch_queue_mem #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) uMem (
    .Clk   (Clk),
    .wrEn  (pushEn),
    .wrAddr(wrPtr),
    .wrData(packEntry(enq_instr, enq_pc4)),
    .rdAddr(rdPtr),
    .rdData(headEntry)
  );

  assign deq_instr = empty ? NOP_INSTR : headEntry[63:32];
  assign deq_pc4   = empty ? 32'h0     : headEntry[31:0];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Only flushes that actually threw work away are counted.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      flush_events <= '0;
    end else if (flush && !empty && (flush_events != '1)) begin
      flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        reset;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_instr = '0;
  logic [31:0] enq_pc4 = '0;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc4;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] flush_events;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(2), .CNT_W(16)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_instr   (enq_instr),
    .enq_pc4     (enq_pc4),
    .deq_ready   (deq_ready),
    .deq_valid   (deq_valid),
    .deq_instr   (deq_instr),
    .deq_pc4     (deq_pc4),
    .flush       (flush),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .flush_events(flush_events)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: a queue of {instr, pc4} plus a flush tally.
  logic [63:0] mq[$];
  int          mFlushEvents = 0;

  always @(posedge Clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mFlushEvents = 0;
    end else begin
      bit doPush, doPop;
      doPush = enq_valid && (mq.size() < DEPTH) && !flush;
      doPop  = deq_ready && (mq.size() > 0) && !flush;
      if (flush) begin
        if (mq.size() != 0 && mFlushEvents != 65535) mFlushEvents++;
        mq.delete();
      end else begin
        if (doPop) void'(mq.pop_front());
        if (doPush) mq.push_back({enq_instr, enq_pc4});
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (checkEn) begin
      logic [63:0] head;
      head = (mq.size() > 0) ? mq[0] : 64'h0;
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_empty", 64'(empty), 64'(mq.size() == 0));
      chk("m_full", 64'(full), 64'(mq.size() == DEPTH));
      chk("m_enq_ready", 64'(enq_ready), 64'(mq.size() != DEPTH));
      chk("m_deq_valid", 64'(deq_valid), 64'(mq.size() != 0));
      chk("m_deq_instr", 64'(deq_instr), 64'(head[63:32]));
      chk("m_deq_pc4", 64'(deq_pc4), 64'(head[31:0]));
      chk("m_flush_events", 64'(flush_events), 64'(mFlushEvents));
    end
  end

  // Apply one cycle of inputs from just after an edge; return 1 time unit past the next edge.
  task automatic cyc(input logic ev, input logic [31:0] ins, input logic [31:0] pc,
                     input logic dr, input logic fl);
    enq_valid = ev;
    enq_instr = ins;
    enq_pc4   = pc;
    deq_ready = dr;
    flush     = fl;
    @(posedge Clk);
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  logic [31:0] fillInstr [4] = '{32'h20080005, 32'h20090007, 32'h01095020, 32'hAC0A0000};
  logic [31:0] fillPc4   [4] = '{32'h4, 32'h8, 32'hC, 32'h10};

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_deq_instr", 64'(deq_instr), 64'd0);
    chk("rst_flush_events", 64'(flush_events), 64'd0);
    checkEn = 1'b1;
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("idle_count", 64'(count), 64'd0);

    // Fill; first push while empty must not bypass to the output.
    enq_valid = 1'b1; enq_instr = fillInstr[0]; enq_pc4 = fillPc4[0];
    #2;
    chk("no_bypass", 64'(deq_valid), 64'd0);
    @(posedge Clk); #1;
    enq_valid = 1'b0;
    chk("visible_next", 64'(deq_instr), 64'h20080005);
    for (int i = 1; i < 4; i++) cyc(1, fillInstr[i], fillPc4[i], 0, 0);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_enq_ready", 64'(enq_ready), 64'd0);
    cyc(1, 32'hDEADBEEF, 32'h14, 0, 0);
    chk("fifth_ignored", 64'(count), 64'd4);

    for (int i = 0; i < 4; i++) begin
      chk("drain_instr", 64'(deq_instr), 64'(fillInstr[i]));
      chk("drain_pc4", 64'(deq_pc4), 64'(fillPc4[i]));
      cyc(0, 0, 0, 1, 0);
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_nop", 64'(deq_instr), 64'd0);
    cyc(0, 0, 0, 1, 0);
    chk("pop_empty_count", 64'(count), 64'd0);

    // Steady push+pop at count 2 across pointer wrap.
    cyc(1, 32'h10000000, 32'h100, 0, 0);
    cyc(1, 32'h10000001, 32'h104, 0, 0);
    for (int k = 2; k < 8; k++) begin
      cyc(1, 32'h10000000 + 32'(k), 32'h100 + 32'(4 * k), 1, 0);
      chk("pp_count", 64'(count), 64'd2);
    end
    chk("pp_head", 64'(deq_instr), 64'h10000006);
    chk("pp_head_pc4", 64'(deq_pc4), 64'h118);

    // Full with deq_ready: pop only.
    cyc(1, 32'h10000008, 32'h120, 0, 0);
    cyc(1, 32'h10000009, 32'h124, 0, 0);
    chk("full_again", 64'(count), 64'd4);
    cyc(1, 32'h00000BAD, 32'h999, 1, 0);
    chk("full_pop_only", 64'(count), 64'd3);
    chk("full_pop_head", 64'(deq_instr), 64'h10000007);

    // Flush overrides push and pop.
    cyc(1, 32'h0000F00D, 32'h200, 1, 1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_deq_valid", 64'(deq_valid), 64'd0);
    chk("flush_events1", 64'(flush_events), 64'd1);
    cyc(0, 0, 0, 0, 1);
    chk("flush_empty_events", 64'(flush_events), 64'd1);
    cyc(1, 32'h22220000, 32'h300, 0, 0);
    chk("post_flush_head", 64'(deq_instr), 64'h22220000);

    // Asynchronous reset between edges.
    cyc(1, 32'h22220001, 32'h304, 0, 0);
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_instr", 64'(deq_instr), 64'd0);
    chk("async_events", 64'(flush_events), 64'd0);
    @(posedge Clk); #1;
    reset = 1'b1;
    cyc(0, 0, 0, 1, 0);
    chk("after_rst_empty", 64'(empty), 64'd1);
    cyc(0, 0, 0, 0, 0);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
